param_mem: RTL and testbench

PARAM_MEM -- requirements
Module: param_mem

---
 rtl/param_mem.sv | 130 +++++++++++++
 tb/tb_param_mem.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_mem.sv
// Parameterised single-port RAM: byte-masked writes, read-first, 1- or 2-cycle read latency.
// Optional access counters (wr_cnt/rd_cnt) are compiled in when PARAM_MEM_STATS_EN is defined.
module param_mem #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   data_out,
  output logic                valid_out,
  output logic                addr_err
`ifdef PARAM_MEM_STATS_EN
  ,
  output logic [15:0]         wr_cnt,
  output logic [15:0]         rd_cnt
`endif
);

  localparam int unsigned NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid_out;
  logic              r_addr_err;

  logic              w_in_range;
  logic              w_wr;
  logic              w_rd;
  logic [DATA_W-1:0] w_mem_word;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;

  // Request decode; out-of-range reads see zero instead of indexing past the array
  assign w_in_range = (32'(addr) < 32'(DEPTH));
  assign w_wr       = en & wr_en & w_in_range;
  assign w_rd       = en & ~wr_en;
  assign w_mem_word = w_in_range ? r_mem[addr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      for (int b = 0; b < int'(NBYTES); b++) begin
        if (byte_en[b]) begin
          r_mem[addr][8*b +: 8] <= data_in[8*b +: 8];
        end
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              r_p_valid;
      logic [ADDR_W-1:0] r_p_addr;
      logic [DATA_W-1:0] r_p_word;

      // Array is sampled at the request edge, so a later write cannot leak into this read
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_p_valid <= 1'b0;
          r_p_addr  <= '0;
          r_p_word  <= '0;
        end else begin
          r_p_valid <= w_rd;
          if (w_rd) begin
            r_p_addr <= addr;
            r_p_word <= w_mem_word;
          end
        end
      end

      assign w_out_valid = r_p_valid;
      assign w_out_data  = (32'(r_p_addr) < 32'(DEPTH)) ? r_p_word : '0;
    end else begin : g_lat1
      assign w_out_valid = w_rd;
      assign w_out_data  = w_mem_word;
    end
  endgenerate

  // Output stage: data holds its last read value between valid cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_valid_out <= w_out_valid;
      r_addr_err  <= en & ~w_in_range;
      if (w_out_valid) begin
        r_data_out <= w_out_data;
      end
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign addr_err  = r_addr_err;

`ifdef PARAM_MEM_STATS_EN
  logic [15:0] r_wr_cnt;
  logic [15:0] r_rd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
      if (w_rd & w_in_range) begin
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
    end
  end

  assign wr_cnt = r_wr_cnt;
  assign rd_cnt = r_rd_cnt;
`endif

endmodule

// File: tb/tb_param_mem.sv
// Bench for param_mem: three instances (LAT1/DEPTH16, LAT2/DEPTH16, LAT1/DEPTH12) on shared stimulus,
// checked every cycle against a scheduled-result memory model plus hand-computed literals.
module tb_param_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  byte_en = '0;

  logic [31:0] dout [3];
  logic        vout [3];
  logic        aerr [3];
`ifdef PARAM_MEM_STATS_EN
  logic [15:0] wcnt [3];
  logic [15:0] rcnt [3];
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    param_mem #(
      .DATA_W  (32),
      .DEPTH   ((g == 2) ? 12 : 16),
      .READ_LAT((g == 1) ? 2 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .wr_en    (wr_en),
      .addr     (addr),
      .data_in  (data_in),
      .byte_en  (byte_en),
      .data_out (dout[g]),
      .valid_out(vout[g]),
      .addr_err (aerr[g])
`ifdef PARAM_MEM_STATS_EN
      ,
      .wr_cnt   (wcnt[g]),
      .rd_cnt   (rcnt[g])
`endif
    );
  end

  function automatic int dep_of(input int c);
    return (c == 2) ? 12 : 16;
  endfunction

  function automatic int lat_of(input int c);
    return (c == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: memory contents plus a due-cycle schedule of read results
  logic [31:0] m    [3][16];
  bit          ev   [3][4];
  logic [31:0] ed   [3][4];
  logic [31:0] last [3];
  logic [15:0] mw   [3];
  logic [15:0] mr   [3];
  int          cyc = 0;

  initial begin
    logic       s_rst, s_en, s_wr, inr, exp_v, exp_e;
    logic [3:0] s_a, s_be;
    logic [31:0] s_d;
    int slot;
    forever begin
      @(posedge clk);
      s_rst = rst; s_en = en; s_wr = wr_en; s_a = addr; s_d = data_in; s_be = byte_en;
      @(negedge clk);
      if (s_rst || rst) begin
        for (int c = 0; c < 3; c++) begin
          for (int a = 0; a < 16; a++) m[c][a] = '0;
          for (int s = 0; s < 4; s++) ev[c][s] = 1'b0;
          last[c] = '0; mw[c] = '0; mr[c] = '0;
          chk($sformatf("rst_valid[%0d]", c), 32'(vout[c]), 32'd0);
          chk($sformatf("rst_data[%0d]", c), dout[c], 32'd0);
          chk($sformatf("rst_err[%0d]", c), 32'(aerr[c]), 32'd0);
        end
      end else begin
        cyc++;
        for (int c = 0; c < 3; c++) begin
          inr = (int'(s_a) < dep_of(c));
          exp_e = s_en && !inr;
          if (s_en && !s_wr) begin
            slot = (cyc + lat_of(c) - 1) % 4;
            ev[c][slot] = 1'b1;
            ed[c][slot] = inr ? m[c][s_a] : 32'd0;
            if (inr) mr[c] = mr[c] + 16'd1;
          end
          if (s_en && s_wr && inr) begin
            for (int b = 0; b < 4; b++)
              if (s_be[b]) m[c][s_a][8*b +: 8] = s_d[8*b +: 8];
            mw[c] = mw[c] + 16'd1;
          end
          slot = cyc % 4;
          exp_v = ev[c][slot];
          if (exp_v) last[c] = ed[c][slot];
          ev[c][slot] = 1'b0;
          chk($sformatf("valid[%0d]", c), 32'(vout[c]), 32'(exp_v));
          chk($sformatf("data[%0d]", c), dout[c], last[c]);
          chk($sformatf("addr_err[%0d]", c), 32'(aerr[c]), 32'(exp_e));
`ifdef PARAM_MEM_STATS_EN
          chk($sformatf("wr_cnt[%0d]", c), 32'(wcnt[c]), 32'(mw[c]));
          chk($sformatf("rd_cnt[%0d]", c), 32'(rcnt[c]), 32'(mr[c]));
`endif
        end
      end
    end
  end

  task automatic req(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    en = 1'b1; wr_en = w; addr = a; data_in = d; byte_en = be;
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) chk("lit_reset_data", dout[c], 32'd0);
    #1 rst = 1'b0;

    // Basic write then read; LAT2 instance lags one cycle
    req(1'b1, 4'd5, 32'hDEADBEEF, 4'hF);
    req(1'b0, 4'd5, 32'h0, 4'h0);
    idle();
    chk("lit_rd5_valid_l1", 32'(vout[0]), 32'd1);
    chk("lit_rd5_data_l1", dout[0], 32'hDEADBEEF);
    chk("lit_rd5_valid_l2_early", 32'(vout[1]), 32'd0);
    idle();
    chk("lit_rd5_valid_l2", 32'(vout[1]), 32'd1);
    chk("lit_rd5_data_l2", dout[1], 32'hDEADBEEF);
    chk("lit_hold_l1", dout[0], 32'hDEADBEEF);

    // Byte-masked write, then an all-zero mask that must change nothing
    req(1'b1, 4'd3, 32'h11223344, 4'hF);
    req(1'b1, 4'd3, 32'hAABBCCDD, 4'b0101);
    req(1'b0, 4'd3, 32'h0, 4'h0);
    idle();
    chk("lit_bytemask", dout[0], 32'h11BB33DD);
    req(1'b1, 4'd3, 32'hFFFFFFFF, 4'h0);
    req(1'b0, 4'd3, 32'h0, 4'h0);
    idle();
    chk("lit_zero_mask", dout[0], 32'h11BB33DD);

    // Back-to-back reads through the two-stage pipeline
    req(1'b1, 4'd0, 32'hA0A0A0A0, 4'hF);
    req(1'b1, 4'd1, 32'hB1B1B1B1, 4'hF);
    req(1'b1, 4'd2, 32'hC2C2C2C2, 4'hF);
    req(1'b0, 4'd0, 32'h0, 4'h0);
    req(1'b0, 4'd1, 32'h0, 4'h0);
    chk("lit_b2b_l2_first_early", 32'(vout[1]), 32'd0);
    req(1'b0, 4'd2, 32'h0, 4'h0);
    chk("lit_b2b_l2_d0", dout[1], 32'hA0A0A0A0);
    idle();
    chk("lit_b2b_l2_d1", dout[1], 32'hB1B1B1B1);
    idle();
    chk("lit_b2b_l2_d2", dout[1], 32'hC2C2C2C2);
    chk("lit_b2b_l2_v2", 32'(vout[1]), 32'd1);
    idle();
    chk("lit_b2b_l2_end", 32'(vout[1]), 32'd0);

    // Out-of-range access on the 12-word instance
    req(1'b1, 4'd14, 32'h5, 4'hF);
    idle();
    chk("lit_oor_err_pulse", 32'(aerr[2]), 32'd1);
    chk("lit_oor_err_inrange", 32'(aerr[0]), 32'd0);
    idle();
    chk("lit_oor_err_drop", 32'(aerr[2]), 32'd0);
    for (int a = 0; a < 12; a++) req(1'b0, 4'(a), 32'h0, 4'h0);
    req(1'b0, 4'd14, 32'h0, 4'h0);
    idle();
    chk("lit_oor_rd_data", dout[2], 32'd0);
    chk("lit_oor_rd_valid", 32'(vout[2]), 32'd1);
    chk("lit_oor_rd_inrange", dout[0], 32'h5);

    // Read-first: read captured before the following write lands
    req(1'b1, 4'd7, 32'h9, 4'hF);
    req(1'b0, 4'd7, 32'h0, 4'h0);
    req(1'b1, 4'd7, 32'h1, 4'hF);
    chk("lit_rf_old_l1", dout[0], 32'h9);
    idle();
    chk("lit_rf_old_l2", dout[1], 32'h9);
    req(1'b0, 4'd7, 32'h0, 4'h0);
    idle();
    chk("lit_rf_new_l1", dout[0], 32'h1);
    idle();
    chk("lit_rf_new_l2", dout[1], 32'h1);

    // Reset while a two-cycle read is in flight
    req(1'b0, 4'd2, 32'h0, 4'h0);
    @(negedge clk);
    en = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("lit_midrst_valid", 32'(vout[1]), 32'd0);
    chk("lit_midrst_data", dout[1], 32'd0);
    #1 rst = 1'b0;
    for (int a = 0; a < 16; a++) req(1'b0, 4'(a), 32'h0, 4'h0);
    idle();
    idle();
    chk("lit_post_rst_l2", dout[1], 32'd0);
    chk("lit_post_rst_l1", dout[0], 32'd0);

`ifdef PARAM_MEM_STATS_EN
    for (int i = 0; i < 32'h10000; i++) req(1'b1, 4'd0, 32'(i), 4'hF);
    idle();
    chk("lit_wr_cnt_wrap", 32'(wcnt[0]), 32'd0);
    chk("lit_rd_cnt16", 32'(rcnt[0]), 32'd16);
    chk("lit_rd_cnt12", 32'(rcnt[2]), 32'd12);
`endif

    idle();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
